labeled_route_sink: RTL and testbench

Receiving end of a label-carrying data stream, consuming the (label, data) pairs produced by the team's label-propagation pipelines. It splits a single labeled input stream into two per-domain output channels, L and H. Each channel has its own buffering, so no H-domain state, data or backpressure can influence any L-labeled signal. It sits at the boundary where mixed-label traffic is handed to domain-specific consumers.

---
 rtl/labeled_route_sink_pkg.sv | 12 +
 rtl/labeled_route_sink_fifo.sv | 65 ++++++
 rtl/labeled_route_sink.sv | 78 +++++++
 tb/tb_labeled_route_sink.sv | 136 +++++++++++++
 4 files changed

// File: rtl/labeled_route_sink_pkg.sv
// rtl/labeled_route_sink_pkg.sv - shared label encoding and sizing helper for the labeled route sink
package labeled_route_sink_pkg;

  localparam int LBL_W = 1;
  localparam logic [LBL_W-1:0] LBL_L = 1'b0;
  localparam logic [LBL_W-1:0] LBL_H = 1'b1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/labeled_route_sink_fifo.sv
// rtl/labeled_route_sink_fifo.sv - single-domain FIFO with scrub-on-pop and optional drop-on-full
module labeled_fifo
  import labeled_route_sink_pkg::*;
#(
  parameter int DW           = 8,
  parameter int DEPTH        = 4,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          empty;
  logic          pop_en;
  logic          push_en;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_en  = pop_ready && !empty;
  // A full drop-mode FIFO can still take the push when its head leaves this cycle.
  assign push_en = push && (!full || (DROP_ON_FULL && pop_en));
  assign ovf     = DROP_ON_FULL && push && full && !pop_en;

  assign pop_valid = !empty;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Scrub first so a full push+pop onto the same slot keeps the new data.
      if (pop_en) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/labeled_route_sink.sv
// rtl/labeled_route_sink.sv - splits a labeled stream into isolated L and H domain channels
module labeled_route_sink
  import labeled_route_sink_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LBL_W-1:0] in_lbl,
  input  logic [DW-1:0]    in_data,
  output logic             l_valid,
  input  logic             l_ready,
  output logic [DW-1:0]    l_data,
  output logic             h_valid,
  input  logic             h_ready,
  output logic [DW-1:0]    h_data,
  output logic [CW-1:0]    h_ovf_cnt
);

  logic l_full;
  logic l_push;
  logic l_ovf_unused;
  logic h_push;
  logic h_ovf;
  logic h_full_unused;
  logic accept;

  // in_ready sees only L state, so H occupancy can never leak into L timing.
  assign in_ready = (in_lbl == LBL_H) ? 1'b1 : !l_full;
  assign accept   = in_valid && in_ready;
  assign l_push   = accept && (in_lbl == LBL_L);
  assign h_push   = accept && (in_lbl == LBL_H);

  labeled_fifo #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .DROP_ON_FULL (1'b0)
  ) u_l_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (l_push),
    .push_data (in_data),
    .pop_ready (l_ready),
    .pop_valid (l_valid),
    .pop_data  (l_data),
    .full      (l_full),
    .ovf       (l_ovf_unused)
  );

  labeled_fifo #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .DROP_ON_FULL (1'b1)
  ) u_h_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (h_push),
    .push_data (in_data),
    .pop_ready (h_ready),
    .pop_valid (h_valid),
    .pop_data  (h_data),
    .full      (h_full_unused),
    .ovf       (h_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      h_ovf_cnt <= '0;
    end else if (h_ovf && (h_ovf_cnt != '1)) begin
      h_ovf_cnt <= h_ovf_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_labeled_route_sink.sv
// tb/tb_labeled_route_sink.sv - self-checking bench for labeled_route_sink
module tb_labeled_route_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_lbl;
  logic [7:0] in_data;
  logic       l_ready;
  logic       h_ready;

  logic       in_ready, l_valid, h_valid;
  logic [7:0] l_data, h_data, h_ovf_cnt;
  logic       s_in_ready, s_l_valid, s_h_valid;
  logic [7:0] s_l_data, s_h_data;
  logic [1:0] s_h_ovf_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] lq[$];
  logic [7:0] hq[$];
  int ovf8 = 0;
  int ovf2 = 0;

  always #5 clk = ~clk;

  labeled_route_sink #(.DW(8), .DEPTH(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lbl(in_lbl), .in_data(in_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data),
    .h_ovf_cnt(h_ovf_cnt)
  );

  labeled_route_sink #(.DW(8), .DEPTH(4), .CW(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_lbl(in_lbl), .in_data(in_data),
    .l_valid(s_l_valid), .l_ready(l_ready), .l_data(s_l_data),
    .h_valid(s_h_valid), .h_ready(h_ready), .h_data(s_h_data),
    .h_ovf_cnt(s_h_ovf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] el, eh;
    el = (lq.size() > 0) ? lq[0] : 8'h00;
    eh = (hq.size() > 0) ? hq[0] : 8'h00;
    chk("l_valid", l_valid, lq.size() != 0);
    chk("l_data", l_data, el);
    chk("h_valid", h_valid, hq.size() != 0);
    chk("h_data", h_data, eh);
    chk("h_ovf_cnt", h_ovf_cnt, ovf8);
    chk("s_l_valid", s_l_valid, lq.size() != 0);
    chk("s_l_data", s_l_data, el);
    chk("s_h_valid", s_h_valid, hq.size() != 0);
    chk("s_h_data", s_h_data, eh);
    chk("s_h_ovf_cnt", s_h_ovf_cnt, ovf2);
  endtask

  // One clock: drive, check in_ready, advance model at the edge, check outputs.
  task automatic step(input logic v, input logic lbl, input logic [7:0] d,
                      input logic lr, input logic hr, input logic r);
    logic exp_rdy;
    logic acc;
    rst = r; in_valid = v; in_lbl = lbl; in_data = d; l_ready = lr; h_ready = hr;
    #1;
    exp_rdy = lbl ? 1'b1 : (lq.size() < 4);
    chk("in_ready", in_ready, exp_rdy);
    chk("s_in_ready", s_in_ready, exp_rdy);
    @(posedge clk);
    if (r) begin
      lq.delete(); hq.delete(); ovf8 = 0; ovf2 = 0;
    end else begin
      acc = v && exp_rdy;
      if (lr && lq.size() > 0) void'(lq.pop_front());
      if (hr && hq.size() > 0) void'(hq.pop_front());
      if (acc && !lbl) lq.push_back(d);
      if (acc && lbl) begin
        if (hq.size() < 4) hq.push_back(d);
        else begin
          if (ovf8 < 255) ovf8++;
          if (ovf2 < 3) ovf2++;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_lbl = 1'b0; in_data = '0; l_ready = 1'b0; h_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    step(1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    repeat (600) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 8'($urandom),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 79) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
